// File: rtl/ghrd_pio_debounce.sv
// WIDTH-bit input PIO bank with synchroniser, debounce, edge capture and irq, plus
// a WIDTH-bit output bank with atomic set/clear. Define PIO_DEBOUNCE_EN to build the debounce counters.
module ghrd_pio_debounce #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter int unsigned      EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_OUT       = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port
);

    typedef enum logic [1:0] {PRIME_1, PRIME_2, PRIME_LOAD, RUN} prime_t;

    prime_t           state;
    prime_t           state_next;
    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_next;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_next;
    logic [WIDTH-1:0] new_edge;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [31:0]      rd_mux;

    assign wr_data = avs_writedata[WIDTH-1:0];

    if (WIDTH < 32) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^avs_writedata[31:WIDTH];
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt      [WIDTH];
    logic [CW-1:0] cnt_next [WIDTH];

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end
`endif

    // Priming sequencer: stable is loaded straight from sync on the 3rd clock after release.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) state <= PRIME_1;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            PRIME_1:    state_next = PRIME_2;
            PRIME_2:    state_next = PRIME_LOAD;
            PRIME_LOAD: state_next = RUN;
            default:    state_next = RUN;
        endcase
    end

    always_comb begin
        stable_next = stable;
`ifdef PIO_DEBOUNCE_EN
        cnt_next = cnt;
`endif
        if (state == PRIME_LOAD) begin
            stable_next = sync;
        end else if (state == RUN) begin
`ifdef PIO_DEBOUNCE_EN
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync[i] == stable[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable_next[i] = sync[i];
                    cnt_next[i]    = '0;
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
`else
            stable_next = sync;
`endif
        end
    end

    always_comb begin
        rise     = ~stable & stable_next;
        fall     = stable & ~stable_next;
        new_edge = '0;
        if (state == RUN) begin
            case (EDGE_TYPE)
                0:       new_edge = rise;
                1:       new_edge = fall;
                default: new_edge = rise | fall;
            endcase
        end
        edge_clr  = (avs_write && avs_address == 3'd3) ? wr_data : '0;
        // A fresh edge beats a same-cycle write-1-to-clear.
        edge_next = (edge_cap & ~edge_clr) | new_edge;
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            3'd0:    rd_mux[WIDTH-1:0] = stable;
            3'd1:    rd_mux[WIDTH-1:0] = sync;
            3'd2:    rd_mux[WIDTH-1:0] = mask;
            3'd3:    rd_mux[WIDTH-1:0] = edge_cap;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            meta         <= '0;
            sync         <= '0;
            stable       <= '0;
            edge_cap     <= '0;
            mask         <= '0;
            irq          <= 1'b0;
            avs_readdata <= '0;
            out_port     <= RESET_OUT;
        end else begin
            meta     <= in_port;
            sync     <= meta;
            stable   <= stable_next;
            edge_cap <= edge_next;
            irq      <= |(edge_cap & mask);
            if (avs_read) avs_readdata <= rd_mux;
            if (avs_write) begin
                case (avs_address)
                    3'd0:    out_port <= wr_data;
                    3'd2:    mask     <= wr_data;
                    3'd4:    out_port <= out_port | wr_data;
                    3'd5:    out_port <= out_port & ~wr_data;
                    default: ;
                endcase
            end
        end
    end

endmodule
